// File: rtl/cdm16_alu_pkg.sv
// Shared encodings for the CdM-16 ALU: operation classes, function codes and PS flag bit positions.
package cdm16_alu_pkg;

   localparam logic [2:0] ALU_ARITH = 3'd0;
   localparam logic [2:0] ALU_SHIFT = 3'd1;
   localparam logic [2:0] ALU_UNARY = 3'd2;

   localparam logic [2:0] F_ADD   = 3'd0;
   localparam logic [2:0] F_SUB   = 3'd1;
   localparam logic [2:0] F_AND   = 3'd2;
   localparam logic [2:0] F_OR    = 3'd3;
   localparam logic [2:0] F_XOR   = 3'd4;
   localparam logic [2:0] F_BIC   = 3'd5;
   localparam logic [2:0] F_PASSA = 3'd6;
   localparam logic [2:0] F_PASSB = 3'd7;

   localparam logic [2:0] F_SHL  = 3'd0;
   localparam logic [2:0] F_SHR  = 3'd1;
   localparam logic [2:0] F_SHRA = 3'd2;
   localparam logic [2:0] F_ROL  = 3'd3;
   localparam logic [2:0] F_ROR  = 3'd4;
   localparam logic [2:0] F_RCL  = 3'd5;
   localparam logic [2:0] F_RCR  = 3'd6;

   localparam logic [2:0] F_NEG  = 3'd0;
   localparam logic [2:0] F_NOT  = 3'd1;
   localparam logic [2:0] F_SXT  = 3'd2;
   localparam logic [2:0] F_SWAB = 3'd3;

   localparam int FLAG_C = 3;
   localparam int FLAG_V = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 0;

   // Z and N always derive from the result; only C and V depend on the operation.
   function automatic logic [3:0] pack_flags(input logic c, input logic v, input logic [15:0] s);
      logic [3:0] f;
      f         = 4'b0000;
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      f[FLAG_Z] = (s == 16'h0000);
      f[FLAG_N] = s[15];
      return f;
   endfunction

endpackage

// File: rtl/cdm16_alu_shifter.sv
// Combinational shift/rotate unit of the CdM-16 ALU (amount 1..8).
// CDM16_ALU_ROTATE_CARRY_EN enables the 17-bit rotate-through-carry ops RCL/RCR.
module cdm16_alu_shifter
   import cdm16_alu_pkg::*;
(
   input  logic [15:0] a,
   input  logic        cin,
   input  logic [2:0]  func,
   input  logic [3:0]  amount,
   output logic [15:0] result,
   output logic        carry
);

   logic [16:0] shl_w;
   logic [16:0] shr_w;
   logic [16:0] sra_w;
   logic [15:0] rol_r;
   logic [15:0] ror_r;

   // Shifting a guard bit alongside the operand leaves the last bit shifted out in that guard.
   assign shl_w = {1'b0, a} << amount;
   assign shr_w = {a, 1'b0} >> amount;
   assign sra_w = $signed({a, 1'b0}) >>> amount;
   assign rol_r = 16'(({a, a} << amount) >> 16);
   assign ror_r = 16'({a, a} >> amount);

`ifdef CDM16_ALU_ROTATE_CARRY_EN
   logic [16:0] rc_w;
   logic [16:0] rcl_r;
   logic [16:0] rcr_r;

   // Carry sits above bit 15 so the 17-bit rotates are a doubled-vector shift.
   assign rc_w  = {cin, a};
   assign rcl_r = 17'(({rc_w, rc_w} << amount) >> 17);
   assign rcr_r = 17'({rc_w, rc_w} >> amount);
`else
   logic unused_cin;
   assign unused_cin = cin;
`endif

   always_comb begin
      result = a;
      carry  = 1'b0;
      case (func)
         F_SHL: begin
            result = shl_w[15:0];
            carry  = shl_w[16];
         end
         F_SHR: begin
            result = shr_w[16:1];
            carry  = shr_w[0];
         end
         F_SHRA: begin
            result = sra_w[16:1];
            carry  = sra_w[0];
         end
         F_ROL: begin
            result = rol_r;
            carry  = rol_r[0];
         end
         F_ROR: begin
            result = ror_r;
            carry  = ror_r[15];
         end
`ifdef CDM16_ALU_ROTATE_CARRY_EN
         F_RCL: begin
            result = rcl_r[15:0];
            carry  = rcl_r[16];
         end
         F_RCR: begin
            result = rcr_r[15:0];
            carry  = rcr_r[16];
         end
`endif
         default: begin
            result = a;
            carry  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/cdm16_alu.sv
// CdM-16 datapath ALU: combinational result S and flags CVZN, plus a clocked PS flag mirror flags_q.
// Optional macro CDM16_ALU_ROTATE_CARRY_EN enables RCL/RCR in the shifter.
module cdm16_alu
   import cdm16_alu_pkg::*;
#(
   parameter int WIDTH = 16
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic [2:0]       op_type,
   input  logic [2:0]       func,
   input  logic [2:0]       shif_count_ni,
   output logic [WIDTH-1:0] S,
   output logic [3:0]       CVZN,
   input  logic             flags_we,
   output logic [3:0]       flags_q
);

   logic [16:0] sum_add;
   logic [16:0] sum_sub;
   logic [3:0]  amount;
   logic [15:0] sh_result;
   logic        sh_carry;
   logic        c_flag;
   logic        v_flag;

   assign sum_add = {1'b0, A} + {1'b0, B} + {16'h0000, Cin};
   assign sum_sub = {1'b0, A} + {1'b0, ~B} + {16'h0000, ~Cin};
   assign amount  = {1'b0, shif_count_ni} + 4'd1;

   cdm16_alu_shifter u_shifter (
      .a      (A),
      .cin    (Cin),
      .func   (func),
      .amount (amount),
      .result (sh_result),
      .carry  (sh_carry)
   );

   always_comb begin
      S      = A;
      c_flag = 1'b0;
      v_flag = 1'b0;
      case (op_type)
         ALU_ARITH: begin
            case (func)
               F_ADD: begin
                  S      = sum_add[15:0];
                  c_flag = sum_add[16];
                  v_flag = (A[15] == B[15]) && (sum_add[15] != A[15]);
               end
               F_SUB: begin
                  S      = sum_sub[15:0];
                  c_flag = sum_sub[16];
                  v_flag = (A[15] != B[15]) && (sum_sub[15] != A[15]);
               end
               F_AND:   S = A & B;
               F_OR:    S = A | B;
               F_XOR:   S = A ^ B;
               F_BIC:   S = A & ~B;
               F_PASSA: S = A;
               default: S = B;
            endcase
         end
         ALU_SHIFT: begin
            S      = sh_result;
            c_flag = sh_carry;
            v_flag = (func == F_SHL) ? (sh_result[15] ^ sh_carry) : 1'b0;
         end
         ALU_UNARY: begin
            case (func)
               F_NEG: begin
                  S      = ~A + 16'h0001;
                  c_flag = (A != 16'h0000);
                  v_flag = (A == 16'h8000);
               end
               F_NOT:   S = ~A;
               F_SXT:   S = {{8{A[7]}}, A[7:0]};
               F_SWAB:  S = {A[7:0], A[15:8]};
               default: S = A;
            endcase
         end
         default: S = A;
      endcase
   end

   assign CVZN = pack_flags(c_flag, v_flag, S);

   // Reset takes priority over a simultaneous flag write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flags_q <= 4'b0000;
      end else if (flags_we) begin
         flags_q <= CVZN;
      end
   end

endmodule

// File: tb/tb_cdm16_alu.sv
// Scoreboard bench for cdm16_alu: directed vectors push expectations, a negedge monitor pops and compares.
module tb_cdm16_alu;

   logic        clk;
   logic        rst_n;
   logic [15:0] A;
   logic [15:0] B;
   logic        Cin;
   logic [2:0]  op_type;
   logic [2:0]  func;
   logic [2:0]  shif_count_ni;
   logic [15:0] S;
   logic [3:0]  CVZN;
   logic        flags_we;
   logic [3:0]  flags_q;

   typedef struct packed {
      logic [63:0] name;
      logic [15:0] s;
      logic [3:0]  cvzn;
      logic        chk_fq;
      logic [3:0]  fq;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;
   logic vec_valid = 1'b0;

   cdm16_alu #(.WIDTH(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .A             (A),
      .B             (B),
      .Cin           (Cin),
      .op_type       (op_type),
      .func          (func),
      .shif_count_ni (shif_count_ni),
      .S             (S),
      .CVZN          (CVZN),
      .flags_we      (flags_we),
      .flags_q       (flags_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The flags_q expectation in a vector reflects the edge just before it is driven.
   task automatic apply(input logic [63:0] name, input logic [2:0] op, input logic [2:0] fn,
                        input logic [2:0] cnt, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic rst, input logic we,
                        input logic [15:0] es, input logic [3:0] ecvzn,
                        input logic chkfq, input logic [3:0] efq);
      exp_t e;
      @(posedge clk);
      #1;
      op_type       = op;
      func          = fn;
      shif_count_ni = cnt;
      A             = a;
      B             = b;
      Cin           = cin;
      rst_n         = rst;
      flags_we      = we;
      e.name   = name;
      e.s      = es;
      e.cvzn   = ecvzn;
      e.chk_fq = chkfq;
      e.fq     = efq;
      exp_q.push_back(e);
      vec_valid = 1'b1;
   endtask

   always @(negedge clk) begin
      if (vec_valid) begin
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_underflow: output present with no expectation queued");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (S !== e.s) begin
               n_fail++;
               $display("FAIL %0s S: got %h expected %h", e.name, S, e.s);
            end
            if (CVZN !== e.cvzn) begin
               n_fail++;
               $display("FAIL %0s CVZN: got %b expected %b", e.name, CVZN, e.cvzn);
            end
            if (e.chk_fq && (flags_q !== e.fq)) begin
               n_fail++;
               $display("FAIL %0s flags_q: got %b expected %b", e.name, flags_q, e.fq);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; flags_we = 1'b0; A = 16'h0; B = 16'h0; Cin = 1'b0;
      op_type = 3'd0; func = 3'd0; shif_count_ni = 3'd0;

      //     name        op    fn    cnt   A        B        cin  rst  we   S        CVZN     chk  fq
      apply("ADD_OVF",  3'd0, 3'd0, 3'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 4'b0101, 1'b1, 4'b0000);
      apply("ADD_WRAP", 3'd0, 3'd0, 3'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h0000, 4'b1010, 1'b1, 4'b0000);
      apply("ADD_CIN",  3'd0, 3'd0, 3'd0, 16'h1234, 16'h1111, 1'b1, 1'b1, 1'b0, 16'h2346, 4'b0000, 1'b0, 4'b0000);
      apply("SUB_EQ",   3'd0, 3'd1, 3'd0, 16'h0005, 16'h0005, 1'b0, 1'b1, 1'b0, 16'h0000, 4'b1010, 1'b0, 4'b0000);
      apply("SUB_BRW",  3'd0, 3'd1, 3'd0, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 16'hFFFF, 4'b0001, 1'b0, 4'b0000);
      apply("SUB_OVF",  3'd0, 3'd1, 3'd0, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h7FFF, 4'b1100, 1'b0, 4'b0000);
      apply("SUB_CIN",  3'd0, 3'd1, 3'd0, 16'h0010, 16'h0003, 1'b1, 1'b1, 1'b0, 16'h000C, 4'b1000, 1'b0, 4'b0000);
      apply("AND",      3'd0, 3'd2, 3'd0, 16'hF0F0, 16'h3C3C, 1'b0, 1'b1, 1'b0, 16'h3030, 4'b0000, 1'b0, 4'b0000);
      apply("OR",       3'd0, 3'd3, 3'd0, 16'h00F0, 16'h0F00, 1'b1, 1'b1, 1'b0, 16'h0FF0, 4'b0000, 1'b0, 4'b0000);
      apply("XOR",      3'd0, 3'd4, 3'd0, 16'hAAAA, 16'hAAAA, 1'b0, 1'b1, 1'b0, 16'h0000, 4'b0010, 1'b0, 4'b0000);
      apply("BIC",      3'd0, 3'd5, 3'd0, 16'hFF0F, 16'h0F0F, 1'b0, 1'b1, 1'b0, 16'hF000, 4'b0001, 1'b0, 4'b0000);
      apply("PASSA",    3'd0, 3'd6, 3'd0, 16'h8000, 16'h1234, 1'b1, 1'b1, 1'b0, 16'h8000, 4'b0001, 1'b0, 4'b0000);
      apply("PASSB",    3'd0, 3'd7, 3'd0, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 4'b0010, 1'b0, 4'b0000);

      apply("SHL_C",    3'd1, 3'd0, 3'd0, 16'hC001, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h8002, 4'b1001, 1'b0, 4'b0000);
      apply("SHL_V",    3'd1, 3'd0, 3'd0, 16'h4000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h8000, 4'b0101, 1'b0, 4'b0000);
      apply("SHL_8",    3'd1, 3'd0, 3'd7, 16'h00FF, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hFF00, 4'b0101, 1'b0, 4'b0000);
      apply("SHR",      3'd1, 3'd1, 3'd0, 16'h8001, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h4000, 4'b1000, 1'b0, 4'b0000);
      apply("SHRA_1",   3'd1, 3'd2, 3'd0, 16'h8001, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hC000, 4'b1001, 1'b0, 4'b0000);
      apply("SHRA_8",   3'd1, 3'd2, 3'd7, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hFF80, 4'b0001, 1'b0, 4'b0000);
      apply("ROL_8",    3'd1, 3'd3, 3'd7, 16'h8001, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0180, 4'b0000, 1'b0, 4'b0000);
      apply("ROR_1",    3'd1, 3'd4, 3'd0, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h8000, 4'b1001, 1'b0, 4'b0000);
      apply("ROR_4",    3'd1, 3'd4, 3'd3, 16'h1234, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h4123, 4'b0000, 1'b1, 4'b0000);
`ifdef CDM16_ALU_ROTATE_CARRY_EN
      apply("RCL_1",    3'd1, 3'd5, 3'd0, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0001, 4'b1000, 1'b0, 4'b0000);
      apply("RCR_1",    3'd1, 3'd6, 3'd0, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 4'b1010, 1'b0, 4'b0000);
      apply("RCR_2",    3'd1, 3'd6, 3'd1, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h4000, 4'b0000, 1'b0, 4'b0000);
`else
      apply("RCL_OFF",  3'd1, 3'd5, 3'd0, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h8000, 4'b0001, 1'b0, 4'b0000);
      apply("RCR_OFF",  3'd1, 3'd6, 3'd0, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0001, 4'b0000, 1'b0, 4'b0000);
      apply("RCR_OFF2", 3'd1, 3'd6, 3'd1, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 4'b0010, 1'b0, 4'b0000);
`endif
      apply("SH_PASS",  3'd1, 3'd7, 3'd5, 16'h8001, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h8001, 4'b0001, 1'b0, 4'b0000);

      apply("NEG_MIN",  3'd2, 3'd0, 3'd0, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h8000, 4'b1101, 1'b0, 4'b0000);
      apply("NEG_0",    3'd2, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 4'b0010, 1'b0, 4'b0000);
      apply("NEG_1",    3'd2, 3'd0, 3'd0, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hFFFF, 4'b1001, 1'b0, 4'b0000);
      apply("NOT",      3'd2, 3'd1, 3'd0, 16'h00FF, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hFF00, 4'b0001, 1'b0, 4'b0000);
      apply("SXT_NEG",  3'd2, 3'd2, 3'd0, 16'h0080, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hFF80, 4'b0001, 1'b0, 4'b0000);
      apply("SXT_POS",  3'd2, 3'd2, 3'd0, 16'h127F, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h007F, 4'b0000, 1'b0, 4'b0000);
      apply("SWAB",     3'd2, 3'd3, 3'd0, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h3412, 4'b0000, 1'b0, 4'b0000);
      apply("UN_PASS",  3'd2, 3'd5, 3'd0, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 1'b0, 16'h0000, 4'b0010, 1'b0, 4'b0000);
      apply("RSV_3",    3'd3, 3'd0, 3'd0, 16'hABCD, 16'hFFFF, 1'b1, 1'b1, 1'b0, 16'hABCD, 4'b0001, 1'b0, 4'b0000);
      apply("RSV_7",    3'd7, 3'd1, 3'd0, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 1'b0, 16'h0000, 4'b0010, 1'b1, 4'b0000);

      // Flag register: reset beats write, then load, hold, reload, reset again.
      apply("FQ_RSTWE", 3'd0, 3'd0, 3'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 4'b1010, 1'b1, 4'b0000);
      apply("FQ_REL",   3'd0, 3'd0, 3'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h0000, 4'b1010, 1'b1, 4'b0000);
      apply("FQ_LOAD",  3'd0, 3'd1, 3'd0, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 16'hFFFF, 4'b0001, 1'b1, 4'b1010);
      apply("FQ_HOLD",  3'd2, 3'd0, 3'd0, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h8000, 4'b1101, 1'b1, 4'b1010);
      apply("FQ_LOAD2", 3'd2, 3'd0, 3'd0, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h8000, 4'b1101, 1'b1, 4'b1101);
      apply("FQ_RST2",  3'd0, 3'd7, 3'd0, 16'h0000, 16'h5555, 1'b0, 1'b1, 1'b0, 16'h5555, 4'b0000, 1'b1, 4'b0000);

      @(posedge clk);
      #1;
      vec_valid = 1'b0;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout: %0d expectations left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/cdm16_alu.md
Name: cdm16_alu

Overview:
- 16-bit ALU of the CdM-16 core datapath.
- Combinational result S and flags CVZN feed the address bus, busD and PS; data inputs are bus0 (A), bus1 (B) and carry-in.
- Adds one clocked flag register (flags_q), loaded under a write enable, that mirrors the PS[3:0] flag latch.

Parameters:
- WIDTH, 16, data width; only 16 is supported (flag and shift rules assume 16).

Ports:
- clk  in  1  core clock; flags_q updates on rising edge
- rst_n  in  1  synchronous active-low reset
- A  in  16  operand A (bus0)
- B  in  16  operand B (bus1)
- Cin  in  1  carry/borrow in
- op_type  in  3  operation class
- func  in  3  operation within class
- shif_count_ni  in  3  shift count minus one (amount = value+1, range 1..8)
- S  out  16  result, combinational
- CVZN  out  4  flags, combinational: [3]=C, [2]=V, [1]=Z, [0]=N
- flags_we  in  1  load flags_q from CVZN
- flags_q  out  4  registered flags

Behaviour:
- S and CVZN are purely combinational (zero latency) and are independent of clk and rst_n.
- Z = (S==0). N = S[15]. C and V are per class, as below.
- op_type 0, ARITH/LOGIC:
  - func0 ADD: S = A+B+Cin. C = bit16 of the 17-bit sum. V = signed overflow (A[15]==B[15] and S[15]!=A[15]).
  - func1 SUB: S = A+~B+!Cin, i.e. A-B-Cin. C = bit16 of that sum (1 means no borrow). V = (A[15]!=B[15] and S[15]!=A[15]).
  - func2 AND, func3 OR, func4 XOR, func5 BIC (A&~B), func6 pass A, func7 pass B. C=0, V=0.
- op_type 1, SHIFT (amount n = shif_count_ni+1):
  - func0 SHL. func1 SHR logical. func2 SHRA (arithmetic, sign fill).
  - func3 ROL. func4 ROR. func5 RCL, 17-bit rotate through Cin. func6 RCR, 17-bit rotate through Cin.
  - func7: S=A, C=0.
  - C = last bit shifted or rotated out (for RCL/RCR, the final carry position).
  - V = 0, except SHL, where V = S[15] xor C.
- op_type 2, UNARY on A:
  - func0 NEG: S = ~A+1. C = (A!=0). V = (A==16'h8000).
  - func1 NOT. func2 SXT: S = {8{A[7]},A[7:0]}. func3 SWAB: S = {A[7:0],A[15:8]}. func4-7: S=A.
  - C=0 and V=0 for all unary ops except NEG.
- op_type 3-7, reserved: S=A, C=0, V=0; Z and N computed normally.
- All arithmetic is modulo 2^16; wrap-around is expected (16'hFFFF + 1 gives 0 with C=1).
- Cin is ignored by all ops except ADD, SUB, RCL and RCR.
- flags_q:
  - On a rising clk edge with rst_n=0: flags_q <= 0, even if flags_we=1 (reset wins).
  - Else, if flags_we=1: flags_q <= CVZN.
  - Else: hold.
  - Reset mid-operation affects only flags_q, never S or CVZN.
  - Reset value of flags_q is 4'b0000.

Optional Feature:
- Macro: CDM16_ALU_ROTATE_CARRY_EN.
- Defined: SHIFT func5 and func6 implement RCL and RCR as specified.
- Undefined: SHIFT func5 and func6 behave as func7 (S=A, C=0, V=0); Cin is then used only by ADD and SUB.

Decomposition:
- Package cdm16_alu_pkg holds:
  - op_type constants ALU_ARITH=0, ALU_SHIFT=1, ALU_UNARY=2;
  - func constants (F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_BIC, F_PASSA, F_PASSB; F_SHL, F_SHR, F_SHRA, F_ROL, F_ROR, F_RCL, F_RCR; F_NEG, F_NOT, F_SXT, F_SWAB);
  - flag bit indices FLAG_C=3, FLAG_V=2, FLAG_Z=1, FLAG_N=0.
- One sub-module, cdm16_alu_shifter (combinational; inputs A, Cin, func, amount; outputs result and carry), instantiated inside cdm16_alu.

Test Plan:
- ADD: A=16'h7FFF, B=1, Cin=0 -> S=16'h8000, CVZN=4'b0101. A=16'hFFFF, B=1, Cin=0 -> S=0, CVZN=4'b1010.
- SUB: A=5, B=5, Cin=0 -> S=0, CVZN=4'b1010. A=0, B=1, Cin=0 -> S=16'hFFFF, CVZN=4'b0001.
- Shifts:
  - SHRA, A=16'h8001, shif_count_ni=0 -> S=16'hC000, C=1, N=1.
  - ROL, A=16'h8001, shif_count_ni=7 -> S=16'h0180, C=0.
  - RCL (macro defined), A=16'h8000, Cin=1, count 1 -> S=16'h0001, C=1.
- Unary: NEG A=16'h8000 -> S=16'h8000, CVZN=4'b1101. SXT A=16'h0080 -> S=16'hFF80. SWAB A=16'h1234 -> S=16'h3412.
- Logic: BIC A=16'hFF0F, B=16'h0F0F -> S=16'hF000, CVZN=4'b0001 (C=0, V=0).
- flags_q: drive CVZN=4'b1010 with flags_we=1 and rst_n=0 -> flags_q stays 0. Release reset -> next edge flags_q=4'b1010. Drop flags_we and change inputs -> flags_q holds.
